// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte stream among N requesters, up to BURST bytes per grant.
// Latency: 1 cycle to arbitrate in IDLE, then zero-cycle combinational forwarding while in GRANT.
// Backpressure: m_ready feeds straight to the granted requester's s_ready; the grant is held while stalled.
module uart_tx_arbiter #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int BURST = 1,
  localparam int IW   = $clog2(N),
  localparam int CW   = $clog2(BURST + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_valid,
  input  logic [N*W-1:0]  s_data,
  output logic [N-1:0]    s_ready,
  output logic            m_valid,
  output logic [W-1:0]    m_data,
  input  logic            m_ready,
  output logic [IW-1:0]   m_id,
  output logic            busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [IW-1:0] gnt;
  logic [IW-1:0] ptr;
  logic [CW-1:0] beats;

  logic [W-1:0]  lane [N];
  logic [IW-1:0] pick;
  logic          pick_vld;
  logic          hs;
  logic          last_beat;
  logic          release_gnt;
  logic [IW-1:0] gnt_nxt;

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign lane[k] = s_data[k*W +: W];
  end

  // Rotating search: first active requester at or after ptr, wrapping N-1 -> 0.
  // Walking offsets from high to low lets the smallest offset win.
  always_comb begin
    int j;
    logic [IW-1:0] idx;
    pick     = '0;
    pick_vld = 1'b0;
    j        = 0;
    idx      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      idx = IW'(j);
      if (s_valid[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Handshake and release decisions for the current grant; explicit wrap since N may not be 2^IW.
  always_comb begin
    hs          = (state == GRANT) && s_valid[gnt] && m_ready;
    last_beat   = (beats == CW'(BURST - 1));
    release_gnt = (state == GRANT) && ((hs && last_beat) || !s_valid[gnt]);
    gnt_nxt     = (gnt == IW'(N - 1)) ? '0 : gnt + IW'(1);
  end

  // Combinational forwarding of the granted lane; everything quiet in IDLE.
  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    s_ready = '0;
    if (state == GRANT) begin
      m_valid      = s_valid[gnt];
      m_data       = lane[gnt];
      s_ready[gnt] = m_ready;
    end
  end

  assign busy = (state == GRANT);
  assign m_id = gnt;

  // Arbitration FSM: select in IDLE, count beats and release in GRANT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      beats <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt   <= pick;
            beats <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (hs) beats <= beats + CW'(1);
          if (release_gnt) begin
            state <= IDLE;
            ptr   <= gnt_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
